// File: rtl/multicycle_controller.sv
// Multicycle control unit for an RV32I integer subset (R-type, I-ALU, LOAD, STORE).
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK, traps on unsupported encodings and counts retired instructions.
module multicycle_controller #(
    parameter int ALU_CC_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic [6:0]          funct7,
    input  logic [2:0]          funct3,
    input  logic                mem_ready,
    output logic                reg_write,
    output logic                mem2reg,
    output logic                alu_src,
    output logic                mem_write,
    output logic                mem_read,
    output logic [ALU_CC_W-1:0] alu_cc,
    output logic                pc_en,
    output logic                ir_en,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_R     = 2'd0,
        CLS_I     = 2'd1,
        CLS_LOAD  = 2'd2,
        CLS_STORE = 2'd3
    } class_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    localparam logic [3:0] CC_AND  = 4'b0000;
    localparam logic [3:0] CC_OR   = 4'b0001;
    localparam logic [3:0] CC_ADD  = 4'b0010;
    localparam logic [3:0] CC_XOR  = 4'b0011;
    localparam logic [3:0] CC_SLL  = 4'b0100;
    localparam logic [3:0] CC_SRL  = 4'b0101;
    localparam logic [3:0] CC_SUB  = 4'b0110;
    localparam logic [3:0] CC_SLT  = 4'b0111;
    localparam logic [3:0] CC_SLTU = 4'b1000;
    localparam logic [3:0] CC_SRA  = 4'b1101;

    state_t               r_state;
    state_t               w_next_state;
    class_t               r_class;
    logic [ALU_CC_W-1:0]  r_alu_cc;
    logic                 r_alu_src;
    logic [CNT_W-1:0]     r_retired;

    class_t               w_dec_class;
    logic [3:0]           w_dec_cc;
    logic                 w_dec_legal;
    logic                 w_retire;
    logic                 w_drive_alu;

    // funct3 to ALU op; alt selects SUB/SRA on the two funct3 codes that have a variant.
    function automatic logic [3:0] f3_to_cc(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? CC_SUB : CC_ADD;
            3'b001:  return CC_SLL;
            3'b010:  return CC_SLT;
            3'b011:  return CC_SLTU;
            3'b100:  return CC_XOR;
            3'b101:  return alt ? CC_SRA : CC_SRL;
            3'b110:  return CC_OR;
            default: return CC_AND;
        endcase
    endfunction

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_dec_class = CLS_R;
        w_dec_cc    = CC_ADD;
        w_dec_legal = 1'b1;
        case (opcode)
            OP_R: begin
                w_dec_class = CLS_R;
                w_dec_cc    = f3_to_cc(funct3, funct7 == F7_ALT);
                w_dec_legal = (funct7 == F7_BASE) ||
                              ((funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OP_I: begin
                w_dec_class = CLS_I;
                w_dec_cc    = (funct3 == 3'b000) ? CC_ADD : f3_to_cc(funct3, funct7 == F7_ALT);
                if (funct3 == 3'b001)
                    w_dec_legal = (funct7 == F7_BASE);
                else if (funct3 == 3'b101)
                    w_dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            end
            OP_LOAD:  w_dec_class = CLS_LOAD;
            OP_STORE: w_dec_class = CLS_STORE;
            default:  w_dec_legal = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the decode registers are reset too; they are few and keep alu_cc free of X after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_class   <= CLS_R;
            r_alu_cc  <= '0;
            r_alu_src <= 1'b0;
            r_retired <= '0;
        end else begin
            if (r_state == S_DECODE) begin
                r_class   <= w_dec_class;
                r_alu_cc  <= ALU_CC_W'(w_dec_cc);
                r_alu_src <= (w_dec_class != CLS_R);
            end
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign w_drive_alu = (r_state == S_EXECUTE) || (r_state == S_MEM) || (r_state == S_WRITEBACK);
    assign w_retire    = (r_state == S_WRITEBACK) ||
                         ((r_state == S_MEM) && (r_class == CLS_STORE) && mem_ready);

    always_comb begin
        w_next_state = r_state;
        reg_write    = 1'b0;
        mem2reg      = 1'b0;
        mem_write    = 1'b0;
        mem_read     = 1'b0;
        pc_en        = 1'b0;
        ir_en        = 1'b0;
        case (r_state)
            S_FETCH: begin
                // Reset forces FETCH, so the IR load is held off until reset is released.
                ir_en        = reset;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_next_state = w_dec_legal ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                w_next_state = (r_class == CLS_LOAD || r_class == CLS_STORE) ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
                mem_read  = (r_class == CLS_LOAD);
                mem_write = (r_class == CLS_STORE);
                if (mem_ready) begin
                    if (r_class == CLS_LOAD) begin
                        w_next_state = S_WRITEBACK;
                    end else begin
                        pc_en        = 1'b1;
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                reg_write    = 1'b1;
                mem2reg      = (r_class == CLS_LOAD);
                pc_en        = 1'b1;
                w_next_state = S_FETCH;
            end
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    assign alu_cc  = w_drive_alu ? r_alu_cc : '0;
    assign alu_src = w_drive_alu ? r_alu_src : 1'b0;
    assign illegal = (r_state == S_TRAP);
    assign retired = r_retired;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The module SHALL have parameter ALU_CC_W, default 4, meaning the ALU control code width.
REQ-002 The module SHALL have parameter CNT_W, default 16, meaning the retired-instruction counter width.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port opcode, input, 7, Instruction[6:0] from the datapath.
REQ-006 The module SHALL have port funct7, input, 7, Instruction[31:25] from the datapath.
REQ-007 The module SHALL have port funct3, input, 3, Instruction[14:12] from the datapath.
REQ-008 The module SHALL have port mem_ready, input, 1, data-memory completion handshake.
REQ-009 The module SHALL have ports reg_write, mem2reg, alu_src, mem_write, mem_read, each output, 1, the datapath control strobes.
REQ-010 The module SHALL have port alu_cc, output, ALU_CC_W, the ALU operation select.
REQ-011 The module SHALL have ports pc_en and ir_en, each output, 1, the PC-advance and instruction-register load enables.
REQ-012 The module SHALL have port illegal, output, 1, a sticky trap flag.
REQ-013 The module SHALL have port retired, output, CNT_W, the count of completed instructions.

Function
REQ-014 The FSM SHALL have states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, and TRAP.
REQ-015 FETCH SHALL assert ir_en for exactly one cycle, then go to DECODE.
REQ-016 DECODE SHALL register the decoded class and alu_cc, then go to EXECUTE; an unsupported opcode or funct combination SHALL go to TRAP instead.
REQ-017 Supported opcodes SHALL be: R-type 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011.
REQ-018 The alu_cc encoding SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, SRA 1101.
REQ-019 R-type decode by funct3: 000 is ADD when funct7=0000000 and SUB when funct7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 is SRL when funct7=0000000 and SRA when funct7=0100000; 110 OR; 111 AND.
REQ-020 An R-type instruction with any funct7 other than the values valid for its funct3 SHALL be illegal.
REQ-021 I-ALU decode SHALL use the same funct3 map, except funct3=000 is always ADD.
REQ-022 For I-ALU funct3=001, funct7 SHALL be 0000000, otherwise the instruction is illegal.
REQ-023 For I-ALU funct3=101, funct7 SHALL select SRL or SRA as for R-type, otherwise the instruction is illegal.
REQ-024 LOAD and STORE SHALL use alu_cc=ADD; their funct3 SHALL be ignored.
REQ-025 alu_src SHALL be 1 for I-ALU, LOAD, and STORE, and 0 for R-type.
REQ-026 alu_cc and alu_src SHALL be driven from the DECODE registers, stable from EXECUTE through WRITEBACK, and 0 in FETCH, DECODE, and TRAP.
REQ-027 EXECUTE SHALL last one cycle, then go to MEM for LOAD/STORE or to WRITEBACK for R-type and I-ALU.
REQ-028 In MEM, mem_read (LOAD) or mem_write (STORE) SHALL be held high every cycle until a cycle in which mem_ready=1.
REQ-029 On that mem_ready=1 cycle, the FSM SHALL exit MEM: a LOAD goes to WRITEBACK; a STORE pulses pc_en, increments retired, and goes to FETCH.
REQ-030 mem_ready SHALL be ignored outside MEM.
REQ-031 WRITEBACK SHALL last one cycle with reg_write=1, mem2reg=1 for LOAD and 0 otherwise, and pc_en=1; it SHALL increment retired and go to FETCH.
REQ-032 Latency with zero memory wait SHALL be: R-type and I-ALU 4 cycles, STORE 4 cycles, LOAD 5 cycles; each mem_ready wait adds one cycle.
REQ-033 reg_write, mem_write, mem_read, pc_en, and ir_en SHALL never be asserted outside the states named above.
REQ-034 pc_en SHALL be asserted exactly once per retired instruction.
REQ-035 retired SHALL wrap from 2^CNT_W-1 to 0.
REQ-036 TRAP SHALL be absorbing: illegal=1 and all strobes 0 until reset; retired SHALL NOT increment for a trapping instruction.

Reset
REQ-037 While reset=0, the FSM SHALL be in FETCH asynchronously, with all outputs 0, retired=0, and illegal=0.
REQ-038 Reset asserted mid-instruction, including mid-MEM wait, SHALL abort the instruction with no further strobes.
REQ-039 After reset is released, ir_en SHALL assert on the first rising clk edge's cycle.

Verification
REQ-040 R-type ADD (opcode 0110011, funct3 000, funct7 0000000) -> ir_en at cycle 0; alu_cc=0010 and alu_src=0 in cycles 2-3; reg_write=1, mem2reg=0, pc_en=1 at cycle 3; retired=1.
REQ-041 LOAD with mem_ready low for 2 MEM cycles -> mem_read high 3 cycles; then WRITEBACK with mem2reg=1, reg_write=1; total 7 cycles.
REQ-042 STORE with mem_ready=1 immediately -> one mem_write cycle with pc_en in the same cycle; reg_write never asserted; 4 cycles total.
REQ-043 Opcode 1100011, or R-type funct3 001 with funct7 0100000 -> TRAP after DECODE; illegal=1 sticky; no strobes for 20 cycles; retired unchanged.
REQ-044 Reset asserted during a MEM wait -> all outputs 0 immediately; after release, FETCH runs and the next instruction executes correctly.
REQ-045 With CNT_W=4, run 16 I-ALU ADDI instructions -> retired wraps to 0 after the 16th; alu_src=1 throughout EXECUTE.
